// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer block.
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW   = 2'd0,
    PENDING_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    PENDING_LOW  = 2'd3
  } state_t;

  // Wide enough to hold the full stable-cycle count.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock domain.
module debouncer_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic data_in,
  output logic s
);

  if (STAGES < 1) begin : g_bad_stages
    $error("debouncer_synchronizer: STAGES must be >= 1");
  end

  logic [STAGES-1:0] sync;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync <= '0;
    end else begin
      sync[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign s = sync[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Level debouncer: accepts a new level only after DEBOUNCE_CYCLES consecutive matching samples.
// Optional input synchronizer enabled by DEBOUNCER_SYNCHRONIZER_EN.
//
//   state        | meaning
//   STABLE_LOW   | data_out = 0, input agrees
//   PENDING_HIGH | data_out = 0, qualifying a rise
//   STABLE_HIGH  | data_out = 1, input agrees
//   PENDING_LOW  | data_out = 1, qualifying a fall
module debouncer
  import debouncer_pkg::*;
#(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic data_in,
  output logic data_out,
  output logic rising_pulse,
  output logic falling_pulse,
  output logic pending
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("debouncer: STAGES must be >= 1");
  end

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);

  logic        s;
  state_t      state;
  logic [CW-1:0] cnt;

`ifdef DEBOUNCER_SYNCHRONIZER_EN
  debouncer_synchronizer #(.STAGES(STAGES)) u_sync (
    .clock   (clock),
    .resetn  (resetn),
    .data_in (data_in),
    .s       (s)
  );
`else
  assign s = data_in;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= STABLE_LOW;
      cnt           <= '0;
      data_out      <= 1'b0;
      rising_pulse  <= 1'b0;
      falling_pulse <= 1'b0;
    end else begin
      rising_pulse  <= 1'b0;
      falling_pulse <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            // A single-cycle filter accepts on the first differing sample.
            if (DEBOUNCE_CYCLES == 1) begin
              state        <= STABLE_HIGH;
              data_out     <= 1'b1;
              rising_pulse <= 1'b1;
            end else begin
              state <= PENDING_HIGH;
              cnt   <= CW'(1);
            end
          end
        end
        PENDING_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt + CW'(1) == LAST) begin
            state        <= STABLE_HIGH;
            data_out     <= 1'b1;
            rising_pulse <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state         <= STABLE_LOW;
              data_out      <= 1'b0;
              falling_pulse <= 1'b1;
            end else begin
              state <= PENDING_LOW;
              cnt   <= CW'(1);
            end
          end
        end
        PENDING_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt + CW'(1) == LAST) begin
            state         <= STABLE_LOW;
            data_out      <= 1'b0;
            falling_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pending = (state == PENDING_HIGH) || (state == PENDING_LOW);

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share stimulus.
// Model tracks the run length of samples disagreeing with the output.
module tb_debouncer;

  localparam int STAGES = 2;
`ifdef DEBOUNCER_SYNCHRONIZER_EN
  localparam int LAT = STAGES;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic data_in = 1'b0;
  logic [1:0] dout, rp, fp, pend;
  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  debouncer #(.STAGES(STAGES), .DEBOUNCE_CYCLES(4)) dut4 (
    .clock(clk), .resetn(resetn), .data_in(data_in),
    .data_out(dout[0]), .rising_pulse(rp[0]), .falling_pulse(fp[0]), .pending(pend[0])
  );

  debouncer #(.STAGES(STAGES), .DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clk), .resetn(resetn), .data_in(data_in),
    .data_out(dout[1]), .rising_pulse(rp[1]), .falling_pulse(fp[1]), .pending(pend[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  int   dc [2] = '{4, 1};
  logic m_out [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run [2];
  logic sq [$];

  always @(posedge clk) begin
    logic s_now;
    if (!resetn) begin
      sq.delete();
      for (int k = 0; k < LAT; k++) sq.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 1'b0; m_run[i] = 0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      end
    end else begin
      if (LAT == 0) begin
        s_now = data_in;
      end else begin
        s_now = sq.pop_front();
        sq.push_back(data_in);
      end
      for (int i = 0; i < 2; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (s_now != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == dc[i]) begin
            m_out[i]  = s_now;
            m_rise[i] = s_now;
            m_fall[i] = !s_now;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(m_out[i]));
        chk($sformatf("rising_pulse[%0d]", i), 32'(rp[i]), 32'(m_rise[i]));
        chk($sformatf("falling_pulse[%0d]", i), 32'(fp[i]), 32'(m_fall[i]));
        chk($sformatf("pending[%0d]", i), 32'(pend[i]), 32'(m_run[i] > 0));
        chk($sformatf("pulse_excl[%0d]", i), 32'(rp[i] & fp[i]), 32'(0));
      end
      chk("pending_d1", 32'(pend[1]), 32'(0));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts rising edges until the DEBOUNCE_CYCLES=4 output reaches v.
  task automatic measure(input string tag, input logic v, input int expect_edges);
    int edges;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (dout[0] !== v && edges < 40);
    #1;
    chk(tag, 32'(edges), 32'(expect_edges));
  endtask

  initial begin
    int w;
    resetn  = 1'b0;
    data_in = 1'b0;
    step(1);
    check_en = 1'b1;
    step(2);
    chk("rst_data_out", 32'(dout), 32'(0));
    chk("rst_pulses", 32'(rp | fp), 32'(0));
    chk("rst_pending", 32'(pend), 32'(0));
    resetn = 1'b1;
    step(3);

    // Clean rise
    data_in = 1'b1;
    measure("rise_latency", 1'b1, LAT + 4);
    step(8);

    // Bounce on fall
    data_in = 1'b0;
    step(2);
    data_in = 1'b1;
    step(1);
    data_in = 1'b0;
    measure("fall_latency", 1'b0, LAT + 4);
    step(8);

    // Glitch reject
    data_in = 1'b1;
    step(3);
    data_in = 1'b0;
    step(12);
    chk("glitch_out", 32'(dout[0]), 32'(0));
    chk("glitch_pending", 32'(pend[0]), 32'(0));

    // Reset while qualifying
    data_in = 1'b1;
    w = 0;
    while (!pend[0] && w < 20) begin
      step(1);
      w++;
    end
    chk("pending_seen", 32'(pend[0]), 32'(1));
    resetn = 1'b0;
    step(1);
    chk("rst_mid_out", 32'(dout[0]), 32'(0));
    resetn = 1'b1;
    measure("rst_release_latency", 1'b1, LAT + 4);
    step(6);
    data_in = 1'b0;
    step(12);

    // Chatter
    for (int n = 0; n < 50; n++) begin
      data_in = ~data_in;
      step(1);
    end
    chk("chatter_out", 32'(dout[0]), 32'(0));
    data_in = 1'b0;
    step(12);

    // Random holds with occasional reset pulses
    for (int n = 0; n < 120; n++) begin
      int len;
      len = $urandom_range(1, 9);
      data_in = 1'($urandom_range(0, 1));
      resetn = ($urandom_range(0, 24) != 0);
      step(1);
      resetn = 1'b1;
      step(len - 1);
    end
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
